// File: rtl/mmnet_layer_seq_if.sv
// Weight-ROM read port plus compute-engine weight/control port of the layer sequencer.
// Latency: none, signal bundle only.
// Backpressure: wt_ack qualifies wt_req; the engine side is fire-and-forget with an eng_done reply.
interface mmnet_layer_seq_if #(
    parameter int PX_SIZE = 8,
    parameter int ADDR_W  = 12,
    parameter int CH_W    = 4,
    parameter int IDX_W   = 6
);
    logic               wt_req;
    logic [ADDR_W-1:0]  wt_addr;
    logic               wt_ack;
    logic [PX_SIZE-1:0] wt_data;
    logic               eng_wt_valid;
    logic [PX_SIZE-1:0] eng_wt_data;
    logic [IDX_W-1:0]   eng_wt_idx;
    logic [1:0]         eng_stage;
    logic [CH_W-1:0]    eng_ch;
    logic               eng_start;
    logic               eng_done;

    modport master (
        output wt_req, wt_addr, eng_wt_valid, eng_wt_data, eng_wt_idx,
               eng_stage, eng_ch, eng_start,
        input  wt_ack, wt_data, eng_done
    );

    modport slave (
        input  wt_req, wt_addr, eng_wt_valid, eng_wt_data, eng_wt_idx,
               eng_stage, eng_ch, eng_start,
        output wt_ack, wt_data, eng_done
    );
endinterface

// File: rtl/mmnet_layer_seq.sv
// Layer sequencer: walks conv/dwcv/fc channels, streams each channel's weights from ROM to the engine, kicks it, waits.
// Latency: start -> wt_req 1 cycle; per channel W_CH LOAD + SETTLE + KICK + WAIT cycles up to eng_done.
// Backpressure: wt_req/wt_addr hold while wt_ack is low; WAIT gives up after TIMEOUT cycles and raises err.
module mmnet_layer_seq #(
    parameter int PX_SIZE = 8,
    parameter int ADDR_W  = 12,
    parameter int CH_W    = 4,
    parameter int IDX_W   = 6,
    parameter int N_CH0   = 3,
    parameter int N_CH1   = 8,
    parameter int N_CH2   = 10,
    parameter int W_CH0   = 9,
    parameter int W_CH1   = 3,
    parameter int W_CH2   = 32,
    parameter int BASE0   = 0,
    parameter int BASE1   = 27,
    parameter int BASE2   = 51,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    mmnet_layer_seq_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_KICK, S_WAIT} state_t;

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state_q, state_d;
    logic [1:0]         stage_q;
    logic [CH_W-1:0]    ch_q;
    logic [IDX_W-1:0]   idx_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic               wv_q;
    logic [PX_SIZE-1:0] wd_q;
    logic [IDX_W-1:0]   wi_q;

    logic [IDX_W-1:0]   last_idx;
    logic [CH_W-1:0]    last_ch;
    logic [ADDR_W-1:0]  next_base;
    logic               word_acc;
    logic               last_word;
    logic               ch_last;
    logic               stage_last;
    logic               timed_out;

    // Geometry of the stage being walked, and where the following stage starts in the ROM
    always_comb begin
        last_idx  = IDX_W'(W_CH0 - 1);
        last_ch   = CH_W'(N_CH0 - 1);
        next_base = ADDR_W'(BASE1);
        case (stage_q)
            2'd1: begin
                last_idx  = IDX_W'(W_CH1 - 1);
                last_ch   = CH_W'(N_CH1 - 1);
                next_base = ADDR_W'(BASE2);
            end
            2'd2: begin
                last_idx  = IDX_W'(W_CH2 - 1);
                last_ch   = CH_W'(N_CH2 - 1);
                next_base = ADDR_W'(BASE2);
            end
            default: ;
        endcase
    end

    assign word_acc   = (state_q == S_LOAD) && bus.wt_ack;
    assign last_word  = (idx_q == last_idx);
    assign ch_last    = (ch_q == last_ch);
    assign stage_last = (stage_q == 2'd2);
    assign timed_out  = (to_cnt_q == TO_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state; abort overrides start, eng_done and timeout alike
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start) state_d = S_LOAD;
                S_LOAD:   if (word_acc && last_word) state_d = S_SETTLE;
                S_SETTLE: state_d = S_KICK;
                S_KICK:   state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.eng_done)   state_d = (ch_last && stage_last) ? S_IDLE : S_LOAD;
                    else if (timed_out) state_d = S_IDLE;
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Channel/word bookkeeping, weight forwarding to the engine, done pulse and sticky err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q  <= 2'd0;
            ch_q     <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            to_cnt_q <= '0;
            wv_q     <= 1'b0;
            wd_q     <= '0;
            wi_q     <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            wv_q <= 1'b0;
            if (!abort) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            stage_q <= 2'd0;
                            ch_q    <= '0;
                            idx_q   <= '0;
                            addr_q  <= ADDR_W'(BASE0);
                            err     <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        if (bus.wt_ack) begin
                            wv_q   <= 1'b1;
                            wd_q   <= bus.wt_data;
                            wi_q   <= idx_q;
                            idx_q  <= idx_q + 1'b1;
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                    S_KICK: to_cnt_q <= '0;
                    S_WAIT: begin
                        if (bus.eng_done) begin
                            idx_q <= '0;
                            if (!ch_last) begin
                                // channels of a stage are contiguous, so addr_q already points at the next one
                                ch_q <= ch_q + 1'b1;
                            end else if (!stage_last) begin
                                stage_q <= stage_q + 1'b1;
                                ch_q    <= '0;
                                addr_q  <= next_base;
                            end else begin
                                done <= 1'b1;
                            end
                        end else if (timed_out) begin
                            err <= 1'b1;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign bus.wt_req       = (state_q == S_LOAD);
    assign bus.wt_addr      = addr_q;
    assign bus.eng_wt_valid = wv_q;
    assign bus.eng_wt_data  = wd_q;
    assign bus.eng_wt_idx   = wi_q;
    assign bus.eng_stage    = stage_q;
    assign bus.eng_ch       = ch_q;
    assign bus.eng_start    = (state_q == S_KICK);
endmodule

// File: doc/mmnet_layer_seq.md
# mmnet_layer_seq

Layer sequencer for the time-multiplexed MiniMobileNet datapath. It walks the network's three compute stages (conv, depthwise-separable conv, FC) channel by channel. For each channel it fetches that channel's weights from the shared weight ROM, streams them into the single compute engine, kicks the engine and waits for completion. It sits between the top-level controller (`start`/`done`) and the engine/weight-memory pair, and owns all weight addressing.

## Interface
Parameters:
- `PX_SIZE`, 8, bits per weight word
- `ADDR_W`, 12, weight ROM address width
- `CH_W`, 4, width of channel index
- `IDX_W`, 6, width of word-within-channel index
- `N_CH0` / `N_CH1` / `N_CH2`, 3 / 8 / 10, output channels per stage
- `W_CH0` / `W_CH1` / `W_CH2`, 9 / 3 / 32, weight words per channel per stage
- `BASE0` / `BASE1` / `BASE2`, 0 / 27 / 51, ROM base address per stage
- `TIMEOUT`, 1024, max cycles in WAIT before error

Ports:
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a full network pass; sampled only in IDLE
- `abort` in 1: synchronous cancel; effective in any state
- `busy` out 1: high whenever state != IDLE
- `done` out 1: one-cycle pulse when the last FC channel completes
- `err` out 1: sticky timeout flag; cleared by an accepted `start`
- `wt_req` out 1: weight read request
- `wt_addr` out ADDR_W: weight read address
- `wt_ack` in 1: word accepted; `wt_data` is valid this cycle
- `wt_data` in PX_SIZE: weight word
- `eng_wt_valid` out 1: a weight word is presented to the engine
- `eng_wt_data` out PX_SIZE: weight word to the engine
- `eng_wt_idx` out IDX_W: position of the word within the channel
- `eng_stage` out 2: current stage (0 = conv, 1 = dwcv, 2 = fc)
- `eng_ch` out CH_W: current output channel
- `eng_start` out 1: one-cycle engine kick
- `eng_done` in 1: engine finished the current channel

## Operation
- FSM states: IDLE, LOAD, SETTLE, KICK, WAIT.
- **IDLE**
  - `start` = 1 → LOAD.
  - On entry to LOAD: stage = 0, ch = 0, idx = 0, `wt_addr` = BASE0, `err` cleared.
- **LOAD**
  - `wt_req` = 1.
  - On `wt_req && wt_ack`: register `wt_data` and idx onto `eng_wt_*`, then increment idx and `wt_addr`.
  - With `wt_ack` low, `wt_req` and `wt_addr` hold.
  - When the last word (idx = W_CHs−1) is accepted → SETTLE.
- **SETTLE**: one cycle. The last word is visible on `eng_wt_valid`. `wt_req` = 0.
- **KICK**: one cycle with `eng_start` = 1. Timeout counter cleared. Then → WAIT.
- **WAIT**
  - Counter increments every cycle.
  - On `eng_done`:
    - Last channel of a non-final stage: stage+1, ch = 0, `wt_addr` = BASE(stage+1), → LOAD.
    - Otherwise, not the last channel: ch+1, → LOAD. `wt_addr` simply continues, since channels are contiguous in the ROM.
    - Last FC channel: `done` = 1, → IDLE.
  - Counter reaching TIMEOUT−1 with no `eng_done`: `err` = 1, → IDLE, no `done`.
- idx resets to 0 on every entry to LOAD.
- `eng_stage` and `eng_ch` are stable from LOAD entry through WAIT exit.
- `abort` → IDLE next cycle from any state:
  - `wt_req`, `eng_wt_valid`, `eng_start` drop; no `done`.
  - `err` is unchanged.
  - The next `start` restarts at stage 0, ch 0.
- Ignored inputs:
  - `start` while busy.
  - `eng_done` outside WAIT.
  - `wt_ack` while `wt_req` = 0.
- Simultaneous events:
  - `eng_done` on the timeout cycle → `done` wins, no `err`.
  - `abort` beats `start`, `eng_done` and timeout in the same cycle.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `wt_req`, `eng_wt_valid`, `eng_start` = 0; `wt_addr`, `eng_wt_data`, `eng_wt_idx`, `eng_stage`, `eng_ch` = 0.
- All outputs are registered or decoded from the state register; there are no combinational input→output paths.
- `start` sampled at edge t → `busy` and `wt_req` high from cycle t+1.
- `eng_wt_valid` follows its `wt_ack` by exactly one cycle.
- Per-channel overhead with `wt_ack` tied high: W_CHs LOAD cycles + SETTLE + KICK + WAIT cycles up to and including the `eng_done` cycle.
- `done` is high in the same cycle `busy` falls to 0.

## Test plan
- **Reset**: assert `rst_n` = 0 mid-WAIT → all outputs zero immediately (asynchronous). Release and hold `start` = 0 → stays IDLE.
- **Full pass**: `wt_ack` = 1, `eng_done` 3 cycles after each `eng_start`.
  - 21 kicks, with (stage, ch) running (0, 0..2), (1, 0..7), (2, 0..9).
  - `wt_addr` covers 0..370 contiguously.
  - Each conv channel takes 14 cycles.
  - Exactly one `done` pulse.
- **Backpressure**: `wt_ack` alternates 1/0.
  - `wt_addr` holds while unacked.
  - `eng_wt_valid` pulses once per accepted word, with idx 0..8 for conv channels.
- **Timeout**: TIMEOUT = 16, `eng_done` never asserted.
  - `err` = 1 and `busy` = 0 after 16 WAIT cycles; no `done`.
  - Next `start` clears `err`.
- **Abort**: assert `abort` during LOAD of stage 1, ch 2 → `busy` = 0 and `wt_req` = 0 the next cycle. A new `start` issues `wt_addr` = 0 with stage 0.
- **Collisions**:
  - `eng_done` on the timeout cycle → `done`, no `err`.
  - `start` while busy → no restart.
  - `eng_done` in LOAD → ignored.
